// File: rtl/implication_checker.sv
// Synthesizable checker for "a |-> ##DELAY b": tracks overlapping attempts,
// pulses pass/fail per attempt, keeps saturating counters and stamps the first failure.
module implication_checker #(
  parameter int DELAY = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic             a,
  input  logic             b,
  output logic             pass_pulse,
  output logic             fail_pulse,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             pending,
  output logic             sticky_fail,
  output logic [CNT_W-1:0] fail_stamp
);

  localparam int SR_W = (DELAY == 0) ? 1 : DELAY;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [SR_W-1:0]  sr_reg;
  logic [SR_W-1:0]  sr_next;
  logic [CNT_W-1:0] cycle_reg;
  logic [CNT_W-1:0] pass_cnt_reg;
  logic [CNT_W-1:0] fail_cnt_reg;
  logic [CNT_W-1:0] fail_stamp_reg;
  logic             pass_pulse_reg;
  logic             fail_pulse_reg;
  logic             sticky_reg;
  logic             start;
  logic             eval;
  logic             eval_pass;
  logic             eval_fail;

  assign start = en & a;

  // With DELAY=0 the attempt is judged on its own start edge and never queues.
  generate
    if (DELAY == 0) begin : g_overlap
      assign eval       = start;
      assign sr_next[0] = 1'b0;
    end else begin : g_shift
      assign eval       = sr_reg[SR_W-1];
      assign sr_next[0] = start;
      for (genvar gi = 1; gi < SR_W; gi++) begin : g_stage
        assign sr_next[gi] = sr_reg[gi-1];
      end
    end
  endgenerate

  assign eval_pass = eval & b;
  assign eval_fail = eval & ~b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_reg         <= '0;
      cycle_reg      <= '0;
      pass_cnt_reg   <= '0;
      fail_cnt_reg   <= '0;
      fail_stamp_reg <= '0;
      pass_pulse_reg <= 1'b0;
      fail_pulse_reg <= 1'b0;
      sticky_reg     <= 1'b0;
    end else begin
      cycle_reg <= cycle_reg + CNT_ONE;
      if (clear) begin
        sr_reg         <= '0;
        pass_cnt_reg   <= '0;
        fail_cnt_reg   <= '0;
        fail_stamp_reg <= '0;
        pass_pulse_reg <= 1'b0;
        fail_pulse_reg <= 1'b0;
        sticky_reg     <= 1'b0;
      end else begin
        sr_reg         <= sr_next;
        pass_pulse_reg <= eval_pass;
        fail_pulse_reg <= eval_fail;
        if (eval_pass && (pass_cnt_reg != CNT_MAX)) begin
          pass_cnt_reg <= pass_cnt_reg + CNT_ONE;
        end
        if (eval_fail) begin
          if (fail_cnt_reg != CNT_MAX) begin
            fail_cnt_reg <= fail_cnt_reg + CNT_ONE;
          end
          // Only the first failure since reset/clear is timestamped.
          if (!sticky_reg) begin
            sticky_reg     <= 1'b1;
            fail_stamp_reg <= cycle_reg;
          end
        end
      end
    end
  end

  assign pass_pulse  = pass_pulse_reg;
  assign fail_pulse  = fail_pulse_reg;
  assign pass_cnt    = pass_cnt_reg;
  assign fail_cnt    = fail_cnt_reg;
  assign pending     = |sr_reg;
  assign sticky_fail = sticky_reg;
  assign fail_stamp  = fail_stamp_reg;

endmodule
